// File: rtl/activation_checker.sv
// Golden-vector checker for the activation-function datapath: pairs each accepted result with
// its golden ROM word, compares within a tolerance and keeps error statistics for the run.
module activation_checker #(
  parameter int unsigned BITWIDTH    = 18,
  parameter int unsigned MAX_SAMPLES = 40961,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TOLERANCE   = 1,
  parameter int unsigned ERR_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                res_valid,
  input  logic [BITWIDTH-1:0] result,
  output logic                res_ready,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [BITWIDTH-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_idx,
  output logic [BITWIDTH-1:0] first_err_got,
  output logic [BITWIDTH-1:0] first_err_exp,
  output logic [BITWIDTH-1:0] max_abs_err
);

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0]   LastIdx = ADDR_W'(MAX_SAMPLES - 1);
  localparam logic [ADDR_W-1:0]   IdxOne  = ADDR_W'(1);
  localparam logic [ERR_W-1:0]    ErrMax  = '1;
  localparam logic [BITWIDTH:0]   Tol     = (BITWIDTH + 1)'(TOLERANCE);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                accept;
  logic                run_clear;

  // Compare stage: holds one accepted sample until it retires on the following edge.
  logic                cmp_valid_q;
  logic [BITWIDTH-1:0] got_q;
  logic [BITWIDTH-1:0] exp_q;
  logic [ADDR_W-1:0]   cidx_q;

  logic signed [BITWIDTH:0] diff;
  logic [BITWIDTH:0]        abs_err;
  logic                     mismatch;

  assign accept = res_valid & res_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    res_ready = 1'b0;
    rom_addr  = idx_q;
    run_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        rom_addr = '0;
        if (start) begin
          state_d   = StPrime;
          idx_d     = '0;
          run_clear = 1'b1;
        end
      end
      StPrime: begin
        state_d = StRun;
      end
      StRun: begin
        res_ready = 1'b1;
        // Look ahead one address on accept so the ROM word for the next index is ready in time.
        if (res_valid) begin
          idx_d    = idx_q + IdxOne;
          rom_addr = idx_q + IdxOne;
          if (idx_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (start) begin
          state_d   = StPrime;
          idx_d     = '0;
          run_clear = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_valid_q <= 1'b0;
      got_q       <= '0;
      exp_q       <= '0;
      cidx_q      <= '0;
    end else begin
      cmp_valid_q <= accept;
      if (accept) begin
        got_q  <= result;
        exp_q  <= rom_data;
        cidx_q <= idx_q;
      end
    end
  end

  // Sign-extend one bit so the difference of any two words cannot overflow.
  assign diff     = $signed({got_q[BITWIDTH-1], got_q}) - $signed({exp_q[BITWIDTH-1], exp_q});
  assign abs_err  = diff[BITWIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign mismatch = abs_err > Tol;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      max_abs_err   <= '0;
    end else if (run_clear) begin
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      max_abs_err   <= '0;
    end else if (cmp_valid_q) begin
      if (abs_err[BITWIDTH-1:0] > max_abs_err) begin
        max_abs_err <= abs_err[BITWIDTH-1:0];
      end
      if (mismatch) begin
        if (err_count != ErrMax) begin
          err_count <= err_count + ERR_W'(1);
        end
        // The counter saturates rather than wraps, so zero means no mismatch seen yet.
        if (err_count == '0) begin
          first_err_idx <= cidx_q;
          first_err_got <= got_q;
          first_err_exp <= exp_q;
        end
      end
    end
  end

  assign busy = (state_q == StPrime) || (state_q == StRun) || (state_q == StDrain);
  assign done = (state_q == StDone);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_activation_checker.sv
// Randomized scoreboard bench for activation_checker: a golden ROM model feeds the DUT, a
// reference model predicts each run's statistics and a monitor compares them when done rises.
module tb_activation_checker;

  localparam int BW  = 18;
  localparam int N   = 8;
  localparam int AW  = 4;
  localparam int TOL = 1;
  localparam int EW  = 2;
  localparam int SAT = (1 << EW) - 1;

  logic          clock;
  logic          reset;
  logic          start;
  logic          res_valid;
  logic [BW-1:0] result;
  logic          res_ready;
  logic [AW-1:0] rom_addr;
  logic [BW-1:0] rom_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_idx;
  logic [BW-1:0] first_err_got;
  logic [BW-1:0] first_err_exp;
  logic [BW-1:0] max_abs_err;

  activation_checker #(
    .BITWIDTH   (BW),
    .MAX_SAMPLES(N),
    .ADDR_W     (AW),
    .TOLERANCE  (TOL),
    .ERR_W      (EW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .res_valid    (res_valid),
    .result       (result),
    .res_ready    (res_ready),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .first_err_got(first_err_got),
    .first_err_exp(first_err_exp),
    .max_abs_err  (max_abs_err)
  );

  typedef struct {
    int            errs;
    int            fidx;
    logic [BW-1:0] fgot;
    logic [BW-1:0] fexp;
    logic [BW-1:0] maxabs;
    bit            pass;
  } exp_t;

  logic [BW-1:0] rom   [0:(1<<AW)-1];
  logic [BW-1:0] res_v [0:N-1];
  exp_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: per-sample |result - golden| on the signed values, plain integer arithmetic.
  function automatic exp_t model();
    exp_t e;
    int   raw;
    raw      = 0;
    e.errs   = 0;
    e.fidx   = 0;
    e.fgot   = '0;
    e.fexp   = '0;
    e.maxabs = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      int a;
      d = int'($signed(res_v[i])) - int'($signed(rom[i]));
      a = (d < 0) ? -d : d;
      if (a > int'(e.maxabs)) e.maxabs = BW'(a);
      if (a > TOL) begin
        if (raw == 0) begin
          e.fidx = i;
          e.fgot = res_v[i];
          e.fexp = rom[i];
        end
        raw++;
      end
    end
    e.errs = (raw > SAT) ? SAT : raw;
    e.pass = (raw == 0);
    return e;
  endfunction

  function automatic int pick_delta();
    case ($urandom_range(5))
      3:       return ($urandom_range(1) != 0) ? 1 : -1;
      4:       return ($urandom_range(1) != 0) ? 2 : -2;
      5:       return int'($urandom_range(1000)) - 500;
      default: return 0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_idx"}, first_err_idx, 0);
    chk({tag, "_first_got"}, first_err_got, 0);
    chk({tag, "_first_exp"}, first_err_exp, 0);
    chk({tag, "_max_abs"}, max_abs_err, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  // One run; vprob is the percentage of cycles with res_valid high, reset_at < 0 means no abort.
  task automatic do_run(input int vprob, input int reset_at);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    if (reset_at < 0) exp_q.push_back(model());
    @(negedge clock);
    start     = 1'b1;
    res_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk("prime_res_ready", res_ready, 0);
    chk("prime_busy", busy, 1);
    chk("prime_done", done, 0);
    chk("prime_err_clear", err_count, 0);
    chk("prime_max_clear", max_abs_err, 0);
    chk("prime_first_clear", first_err_idx, 0);
    @(negedge clock);
    chk("run_res_ready", res_ready, 1);
    while (k < N) begin
      if (k == reset_at) begin
        res_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      res_valid = ($urandom_range(99) < vprob);
      result    = res_valid ? res_v[k] : BW'($urandom);
      if (res_valid && res_ready) k++;
      @(negedge clock);
      cyc++;
      if (cyc > 200) begin
        chk("accept_timeout", k, N);
        break;
      end
    end
    // Keep valid asserted past the last accept; it must be ignored.
    res_valid = 1'b1;
    result    = BW'($urandom);
    chk("drain_done", done, 0);
    chk("drain_ready", res_ready, 0);
    chk("drain_busy", busy, 1);
    @(negedge clock);
    chk("done_latency", done, 1);
    chk("done_busy", busy, 0);
    @(negedge clock);
    res_valid = 1'b0;
  endtask

  // Counts accepts at the sampling edge; cleared by reset or an accepted start.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset) acc_cnt = 0;
      else if (start && !busy) acc_cnt = 0;
      else if (res_valid && res_ready) acc_cnt++;
    end
  end

  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clock);
      chk("busy_done_excl", busy & done, 0);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_err_count", err_count, e.errs);
          chk("sb_pass", pass, e.pass);
          chk("sb_first_idx", first_err_idx, e.fidx);
          chk("sb_first_got", first_err_got, e.fgot);
          chk("sb_first_exp", first_err_exp, e.fexp);
          chk("sb_max_abs", max_abs_err, e.maxabs);
          chk("sb_accepts", acc_cnt, N);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    result    = '0;
    for (int i = 0; i < (1 << AW); i++) rom[i] = BW'($urandom);
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("idle");

    // Clean run, continuous valid.
    for (int i = 0; i < N; i++) res_v[i] = rom[i];
    do_run(100, -1);

    // Mismatches at index 3 and 6.
    for (int i = 0; i < N; i++) begin
      rom[i]   = BW'($urandom);
      res_v[i] = rom[i];
    end
    rom[3]   = 18'h00110;
    res_v[3] = 18'h00100;
    rom[6]   = 18'h00200;
    res_v[6] = 18'h00205;
    do_run(100, -1);

    // Tolerance boundary and signed comparison.
    for (int i = 0; i < N; i++) begin
      rom[i]   = BW'($urandom);
      res_v[i] = rom[i];
    end
    res_v[0] = rom[0] + 18'd1;
    res_v[1] = rom[1] - 18'd1;
    res_v[2] = rom[2] + 18'd2;
    rom[3]   = 18'h00000;
    res_v[3] = 18'h3FFFF;
    do_run(100, -1);

    // Correct data with random valid gaps.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        rom[i]   = BW'($urandom);
        res_v[i] = rom[i];
      end
      do_run(50, -1);
    end

    // Abort mid-run at sample 4, then a clean run.
    do_run(100, 4);
    do_run(60, -1);

    // Five mismatches saturate a 2-bit counter; restart from DONE must clear everything.
    for (int i = 0; i < N; i++) begin
      rom[i]   = BW'($urandom);
      res_v[i] = rom[i];
    end
    res_v[0] = rom[0] + 18'd7;
    res_v[2] = rom[2] - 18'd3;
    res_v[3] = rom[3] + 18'd40;
    res_v[5] = rom[5] - 18'd9;
    res_v[7] = rom[7] + 18'd2;
    do_run(100, -1);
    for (int i = 0; i < N; i++) res_v[i] = rom[i];
    do_run(70, -1);

    // Random error patterns with gaps.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        rom[i]   = BW'($urandom);
        res_v[i] = rom[i] + BW'(pick_delta());
      end
      do_run(int'($urandom_range(30, 100)), -1);
    end

    repeat (3) @(negedge clock);
    chk("sb_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
